// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state codes and lamp patterns for the intersection controller
package traffic_pkg;

  // Fixed codes: phase is exported as-is for debug/display
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_1    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALLRED_2    = 3'd5
  } state_t;

  // Lamp patterns, bit order {red,yellow,green}
  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable tick-driven down-counter that saturates at zero
module phase_timer #(
  parameter int               TIMER_W   = 8,
  parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               tick,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  // Load wins over counting so a phase entry always starts from a full duration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  // Zero flag qualifies phase exits in the controller
  always_comb begin
    zero = (count == '0);
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - main/side road signal sequencer with pedestrian walk service
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int MAIN_MIN_T   = 10,
  parameter int SIDE_GREEN_T = 6,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 1,
  parameter int TIMER_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               side_req,
  input  logic               ped_req,
  output logic [2:0]         main_lights,
  output logic [2:0]         side_lights,
  output logic               ped_walk,
  output logic [2:0]         phase,
  output logic [TIMER_W-1:0] time_left
);

  // Timer reload values: a phase of N ticks counts N-1 down to 0
  localparam logic [TIMER_W-1:0] LD_MAIN   = TIMER_W'(MAIN_MIN_T - 1);
  localparam logic [TIMER_W-1:0] LD_SIDE   = TIMER_W'(SIDE_GREEN_T - 1);
  localparam logic [TIMER_W-1:0] LD_YELLOW = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] LD_ALLRED = TIMER_W'(ALLRED_T - 1);

  state_t             state;
  state_t             next_state;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_val;
  logic [TIMER_W-1:0] timer_count;
  logic               timer_zero;
  logic               advance;
  logic               enter_side_green;
  logic               ped_pending;
  logic               ped_served;

  assign advance = tick & timer_zero;

  phase_timer #(
    .TIMER_W   (TIMER_W),
    .RESET_VAL (LD_ALLRED)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_load_val),
    .tick     (tick),
    .count    (timer_count),
    .zero     (timer_zero)
  );

  // State register; reset parks in the clearance phase before main green
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ALLRED_2;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and timer reload; any phase change reloads the new phase's duration
  always_comb begin
    next_state     = state;
    timer_load     = 1'b0;
    timer_load_val = LD_ALLRED;
    case (state)
      MAIN_GREEN:  if (advance && (side_req || ped_pending)) next_state = MAIN_YELLOW;
      MAIN_YELLOW: if (advance) next_state = ALLRED_1;
      ALLRED_1:    if (advance) next_state = SIDE_GREEN;
      SIDE_GREEN:  if (advance) next_state = SIDE_YELLOW;
      SIDE_YELLOW: if (advance) next_state = ALLRED_2;
      ALLRED_2:    if (advance) next_state = MAIN_GREEN;
      default:     next_state = ALLRED_2;
    endcase
    if (next_state != state) begin
      timer_load = 1'b1;
      case (next_state)
        MAIN_GREEN:  timer_load_val = LD_MAIN;
        MAIN_YELLOW: timer_load_val = LD_YELLOW;
        SIDE_GREEN:  timer_load_val = LD_SIDE;
        SIDE_YELLOW: timer_load_val = LD_YELLOW;
        default:     timer_load_val = LD_ALLRED;
      endcase
    end
  end

  assign enter_side_green = (state == ALLRED_1) && (next_state == SIDE_GREEN);

  // Pedestrian latch: a request arriving on the side-green entry edge is served
  // by that side green, so the pending flag is cleared rather than re-armed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pending <= 1'b0;
      ped_served  <= 1'b0;
    end else if (enter_side_green) begin
      ped_pending <= 1'b0;
      ped_served  <= ped_pending | ped_req;
    end else if (ped_req) begin
      ped_pending <= 1'b1;
    end
  end

  // Moore lamp decode straight from the state register; unknown codes show all red
  always_comb begin
    main_lights = LT_RED;
    side_lights = LT_RED;
    case (state)
      MAIN_GREEN:  main_lights = LT_GREEN;
      MAIN_YELLOW: main_lights = LT_YELLOW;
      SIDE_GREEN:  side_lights = LT_GREEN;
      SIDE_YELLOW: side_lights = LT_YELLOW;
      default: begin
        main_lights = LT_RED;
        side_lights = LT_RED;
      end
    endcase
  end

  assign ped_walk  = (state == SIDE_GREEN) & ped_served;
  assign phase     = state;
  assign time_left = timer_count;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - directed self-checking bench for traffic_light_fsm
module tb_traffic_light_fsm;

  localparam int TW = 8;
  localparam logic [2:0] P_MG  = 3'd0;
  localparam logic [2:0] P_MY  = 3'd1;
  localparam logic [2:0] P_AR1 = 3'd2;
  localparam logic [2:0] P_SG  = 3'd3;
  localparam logic [2:0] P_SY  = 3'd4;
  localparam logic [2:0] P_AR2 = 3'd5;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          side_req = 1'b0;
  logic          ped_req = 1'b0;
  logic [2:0]    main_lights;
  logic [2:0]    side_lights;
  logic          ped_walk;
  logic [2:0]    phase;
  logic [TW-1:0] time_left;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  traffic_light_fsm #(
    .MAIN_MIN_T   (10),
    .SIDE_GREEN_T (6),
    .YELLOW_T     (3),
    .ALLRED_T     (1),
    .TIMER_W      (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .side_req    (side_req),
    .ped_req     (ped_req),
    .main_lights (main_lights),
    .side_lights (side_lights),
    .ped_walk    (ped_walk),
    .phase       (phase),
    .time_left   (time_left)
  );

  // Expected phase after k ticks of a cycle with continuous demand (24-tick period)
  function automatic logic [2:0] exp_phase(input int k);
    int m;
    m = ((k - 1) % 24) + 1;
    if (m <= 10) return P_MG;
    if (m <= 13) return P_MY;
    if (m == 14) return P_AR1;
    if (m <= 20) return P_SG;
    if (m <= 23) return P_SY;
    return P_AR2;
  endfunction

  function automatic logic [2:0] exp_main(input logic [2:0] p);
    if (p == P_MG) return GRN;
    if (p == P_MY) return YEL;
    return RED;
  endfunction

  function automatic logic [2:0] exp_side(input logic [2:0] p);
    if (p == P_SG) return GRN;
    if (p == P_SY) return YEL;
    return RED;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] p, input logic walk);
    check({tag, "_phase"}, {29'd0, phase}, {29'd0, p});
    check({tag, "_main"}, {29'd0, main_lights}, {29'd0, exp_main(p)});
    check({tag, "_side"}, {29'd0, side_lights}, {29'd0, exp_side(p)});
    check({tag, "_walk"}, {31'd0, ped_walk}, {31'd0, walk});
  endtask

  task automatic tick_once();
    repeat (9) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick = 1'b0;
    side_req = 1'b0;
    ped_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Never both roads showing a non-red aspect
  always @(negedge clk) begin
    if (mon_en) check("no_conflict", {31'd0, (main_lights == RED) || (side_lights == RED)}, 32'd1);
  end

  initial begin
    logic [2:0] p;
    mon_en = 1'b1;

    // Test 1: reset state, then main green held without demand
    repeat (2) @(negedge clk);
    check_state("t1_reset", P_AR2, 1'b0);
    check("t1_reset_time", {24'd0, time_left}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_hold_ar2", {29'd0, phase}, {29'd0, P_AR2});
    for (int k = 1; k <= 60; k++) begin
      tick_once();
      check($sformatf("t1_k%0d_phase", k), {29'd0, phase}, {29'd0, P_MG});
      check($sformatf("t1_k%0d_time", k), {24'd0, time_left}, (k <= 10) ? 32'(10 - k) : 32'd0);
    end

    // Test 2: side_req held, two full 24-tick cycles
    do_reset();
    side_req = 1'b1;
    for (int k = 1; k <= 49; k++) begin
      tick_once();
      check_state($sformatf("t2_k%0d", k), exp_phase(k), 1'b0);
    end

    // Test 3: single-cycle pedestrian pulse during main green
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      tick_once();
      check_state($sformatf("t3_k%0d", k), P_MG, 1'b0);
    end
    @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    for (int k = 5; k <= 24; k++) begin
      tick_once();
      p = exp_phase(k);
      check_state($sformatf("t3_k%0d", k), p, p == P_SG);
    end
    for (int k = 25; k <= 40; k++) begin
      tick_once();
      check_state($sformatf("t3_k%0d", k), P_MG, 1'b0);
    end

    // Test 4: pedestrian request on the exact edge entering side green
    do_reset();
    side_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick_once();
      check($sformatf("t4_k%0d_phase", k), {29'd0, phase}, {29'd0, exp_phase(k)});
    end
    repeat (9) @(negedge clk);
    tick = 1'b1;
    ped_req = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    ped_req = 1'b0;
    side_req = 1'b0;
    check_state("t4_k15", P_SG, 1'b1);
    for (int k = 16; k <= 24; k++) begin
      tick_once();
      p = exp_phase(k);
      check_state($sformatf("t4_k%0d", k), p, p == P_SG);
    end
    for (int k = 25; k <= 39; k++) begin
      tick_once();
      check_state($sformatf("t4_k%0d", k), P_MG, 1'b0);
    end

    // Test 5: asynchronous reset in the middle of a walk-serving side green
    do_reset();
    side_req = 1'b1;
    tick_once();
    tick_once();
    @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    for (int k = 3; k <= 17; k++) begin
      tick_once();
      p = exp_phase(k);
      check_state($sformatf("t5_k%0d", k), p, p == P_SG);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_state("t5_async", P_AR2, 1'b0);
    check("t5_async_time", {24'd0, time_left}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    side_req = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_state("t5_post_ar2", P_AR2, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      tick_once();
      check_state($sformatf("t5_post_k%0d", k), P_MG, 1'b0);
    end

    // Test 6: tick held high, each clock is a tick; cycle is 24 clocks
    do_reset();
    side_req = 1'b1;
    tick = 1'b1;
    for (int k = 1; k <= 49; k++) begin
      @(negedge clk);
      check_state($sformatf("t6_c%0d", k), exp_phase(k), 1'b0);
    end
    tick = 1'b0;
    side_req = 1'b0;

    @(negedge clk);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
